// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and a parity helper.
// The receiver uses the same constants, so keep encodings stable.
package uart_pkg;

  // Parity mode selectors
  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Line FSM state encodings
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE  = 3'd0;
  localparam uart_state_t ST_START = 3'd1;
  localparam uart_state_t ST_DATA  = 3'd2;
  localparam uart_state_t ST_PAR   = 3'd3;
  localparam uart_state_t ST_STOP  = 3'd4;

  // Parity bit for a zero-extended data word; zero padding does not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic x;
    x = ^data;
    case (mode)
      PARITY_EVEN: return x;
      PARITY_ODD:  return ~x;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: registered full/empty/level flags, unreset storage array.
// Push is ignored while full, pop is ignored while empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ready_q;
  assign do_pop  = pop & ~empty_q;

  // Next pointer, level and flag values from the qualified push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LW'(DEPTH));
    empty_d = (level_d == LW'(0));
  end

  // Pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign ready = ready_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO front end plus a baud-tick driven frame FSM.
// All state changes happen on baud_tick cycles; txd/busy are registered and
// reflect the state entered on that tick from the following cycle.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        baud_tick,
  input  logic                        s_valid,
  input  logic [DATA_BITS-1:0]        s_data,
  output logic                        s_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  import uart_pkg::*;

  localparam int          IW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [1:0]  PAR_MODE   = 2'(PARITY);
  localparam logic        HAS_PARITY = (PAR_MODE != PARITY_NONE);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic        LAST_STOP  = 1'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_ready;
  logic                 fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .push   (s_valid),
    .wdata  (s_data),
    .pop    (fifo_pop),
    .rdata  (fifo_head),
    .ready  (fifo_ready),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Frame sequencing: advance one bit per baud_tick, pop the FIFO head when a frame starts.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            par_d    = parity_bit(8'(fifo_head), PAR_MODE);
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_START: begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (idx_q == LAST_IDX) begin
            stop_d  = 1'b0;
            state_d = HAS_PARITY ? ST_PAR : ST_STOP;
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shift_q >> 1;
          end
        end
        ST_PAR: begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (stop_q == LAST_STOP) begin
            // Back-to-back frames go straight to START with no idle bit.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              par_d    = parity_bit(8'(fifo_head), PAR_MODE);
              state_d  = ST_START;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Line level and busy flag for the state being entered.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      ST_PAR:   txd_d = par_d;
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FSM, shift register and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign s_ready = fifo_ready;
  assign txd     = txd_q;
  assign busy    = busy_q;

endmodule
